uvma_axis_protocol_chkr: RTL and testbench

//  Parametrised, synthesisable AXI4-Stream protocol checker; successor to the empty assertion-only checker.

---
 rtl/uvma_axis_chkr_pkg.sv | 22 ++
 rtl/uvma_axis_chkr_sat_cnt.sv | 24 ++
 rtl/uvma_axis_protocol_chkr.sv | 180 ++++++++++++++++++
 tb/tb_uvma_axis_protocol_chkr.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uvma_axis_chkr_pkg.sv
// Shared types and constants for the AXI4-Stream protocol checker.
package uvma_axis_chkr_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  localparam int unsigned E_STABLE    = 0;
  localparam int unsigned E_VAL_DROP  = 1;
  localparam int unsigned E_STRB_KEEP = 2;
  localparam int unsigned E_ROUTE     = 3;
  localparam int unsigned E_TOO_LONG  = 4;
  localparam int unsigned E_STALL     = 5;
  localparam int unsigned NUM_ERRS    = 6;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uvma_axis_chkr_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear together with inc loads 1.
module uvma_axis_chkr_sat_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] cnt
);

  // Count register: clear wins, a same-cycle increment restarts at one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= (inc && (max != '0)) ? WIDTH'(1) : '0;
    end else if (inc && (cnt < max)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uvma_axis_protocol_chkr.sv
// Passive AXI4-Stream protocol checker: handshake stability, strobe/keep,
// routing consistency, packet length and stall timeout.
module uvma_axis_protocol_chkr
  import uvma_axis_chkr_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH   = 32,
  parameter int unsigned TID_WIDTH     = 4,
  parameter int unsigned TDEST_WIDTH   = 4,
  parameter int unsigned TUSER_WIDTH   = 1,
  parameter int unsigned MAX_PKT_LEN   = 256,
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     clear_errs,
  input  logic                     tvalid,
  input  logic                     tready,
  input  logic [TDATA_WIDTH-1:0]   tdata,
  input  logic [TDATA_WIDTH/8-1:0] tstrb,
  input  logic [TDATA_WIDTH/8-1:0] tkeep,
  input  logic                     tlast,
  input  logic [TID_WIDTH-1:0]     tid,
  input  logic [TDEST_WIDTH-1:0]   tdest,
  input  logic [TUSER_WIDTH-1:0]   tuser,
  output logic [NUM_ERRS-1:0]      err_pulse,
  output logic [NUM_ERRS-1:0]      err_sticky,
  output logic [CNT_WIDTH-1:0]     err_cnt,
  output logic [CNT_WIDTH-1:0]     pkt_cnt,
  output logic                     in_pkt
);

  localparam int unsigned TB      = TDATA_WIDTH / 8;
  localparam int unsigned CAP_W   = TDATA_WIDTH + 2 * TB + 1 + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;
  localparam int unsigned ROUTE_W = TID_WIDTH + TDEST_WIDTH;
  localparam int unsigned BEAT_W  = cnt_width(MAX_PKT_LEN + 1);
  localparam int unsigned STALL_W = cnt_width(STALL_TIMEOUT);

  if (TDATA_WIDTH % 8 != 0) begin : g_width_chk
    $error("uvma_axis_protocol_chkr: TDATA_WIDTH must be a multiple of 8");
  end

  state_e               state_q;
  state_e               state_d;
  logic                 cap_en;
  logic                 e_stable;
  logic                 e_val_drop;
  logic [CAP_W-1:0]     cap_q;
  logic [CAP_W-1:0]     cur_beat;
  logic [ROUTE_W-1:0]   route_q;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [STALL_W-1:0]   stall_cnt;
  logic                 hs;
  logic                 stalled;
  logic [NUM_ERRS-1:0]  errs;
  logic [NUM_ERRS-1:0]  errs_en;

  assign hs       = tvalid & tready;
  assign stalled  = tvalid & ~tready;
  assign cur_beat = {tdata, tstrb, tkeep, tlast, tid, tdest, tuser};
  assign errs_en  = enable ? errs : '0;

  // Handshake state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake next state, capture strobe and in-flight beat checks.
  always_comb begin
    state_d    = state_q;
    cap_en     = 1'b0;
    e_stable   = 1'b0;
    e_val_drop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (stalled) begin
          state_d = S_HOLD;
          cap_en  = 1'b1;
        end
      end
      S_HOLD: begin
        e_stable = tvalid & (cur_beat != cap_q);
        if (!tvalid) begin
          state_d    = S_IDLE;
          e_val_drop = 1'b1;
        end else if (tready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Snapshot of the beat presented when a stall begins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_q <= '0;
    end else if (cap_en) begin
      cap_q <= cur_beat;
    end
  end

  // Packet framing and routing latched at the first accepted beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_pkt  <= 1'b0;
      route_q <= '0;
    end else if (hs) begin
      if (!in_pkt) begin
        route_q <= {tid, tdest};
      end
      in_pkt <= ~tlast;
    end
  end

  // Per-cycle error vector on the current sample.
  always_comb begin
    errs               = '0;
    errs[E_STABLE]     = e_stable;
    errs[E_VAL_DROP]   = e_val_drop;
    errs[E_STRB_KEEP]  = tvalid & (|(tstrb & ~tkeep));
    errs[E_ROUTE]      = hs & in_pkt & ({tid, tdest} != route_q);
    errs[E_TOO_LONG]   = (MAX_PKT_LEN != 0) && hs && (beat_cnt == BEAT_W'(MAX_PKT_LEN));
    errs[E_STALL]      = (STALL_TIMEOUT != 0) && stalled &&
                         (stall_cnt == STALL_W'(STALL_TIMEOUT - 1));
  end

  // Pulsed and sticky error flags; clear keeps only this cycle's errors.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_pulse  <= '0;
      err_sticky <= '0;
    end else begin
      err_pulse  <= errs_en;
      err_sticky <= clear_errs ? errs_en : (err_sticky | errs_en);
    end
  end

  uvma_axis_chkr_sat_cnt #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (|errs_en),
    .clr     (clear_errs),
    .max     ({CNT_WIDTH{1'b1}}),
    .cnt     (err_cnt)
  );

  uvma_axis_chkr_sat_cnt #(.WIDTH(CNT_WIDTH)) u_pkt_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (hs & tlast),
    .clr     (1'b0),
    .max     ({CNT_WIDTH{1'b1}}),
    .cnt     (pkt_cnt)
  );

  uvma_axis_chkr_sat_cnt #(.WIDTH(BEAT_W)) u_beat_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (hs & ~tlast),
    .clr     (hs & tlast),
    .max     (BEAT_W'(MAX_PKT_LEN + 1)),
    .cnt     (beat_cnt)
  );

  uvma_axis_chkr_sat_cnt #(.WIDTH(STALL_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (stalled),
    .clr     (~stalled),
    .max     (STALL_W'(STALL_TIMEOUT)),
    .cnt     (stall_cnt)
  );

endmodule

// File: tb/tb_uvma_axis_protocol_chkr.sv
// Bench for uvma_axis_protocol_chkr: directed scenarios plus randomized
// traffic, all compared against a transaction-level reference model.
module tb_uvma_axis_protocol_chkr;

  localparam int DW      = 32;
  localparam int TBW     = DW / 8;
  localparam int MAXLEN  = 4;
  localparam int TIMEOUT = 8;
  localparam int CW      = 6;
  localparam int CMAX    = (1 << CW) - 1;
  localparam int CAP_W   = DW + 2 * TBW + 1 + 4 + 4 + 1;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           enable;
  logic           clear_errs;
  logic           tvalid;
  logic           tready;
  logic [DW-1:0]  tdata;
  logic [TBW-1:0] tstrb;
  logic [TBW-1:0] tkeep;
  logic           tlast;
  logic [3:0]     tid;
  logic [3:0]     tdest;
  logic [0:0]     tuser;
  logic [5:0]     err_pulse;
  logic [5:0]     err_sticky;
  logic [CW-1:0]  err_cnt;
  logic [CW-1:0]  pkt_cnt;
  logic           in_pkt;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state, expressed in terms of the protocol rules.
  bit             m_hold;
  logic [CAP_W-1:0] m_cap;
  int             m_run;
  int             m_beats;
  logic [7:0]     m_route;
  logic [5:0]     m_pulse;
  logic [5:0]     m_sticky;
  int             m_err_cnt;
  int             m_pkt_cnt;

  uvma_axis_protocol_chkr #(
    .TDATA_WIDTH   (DW),
    .TID_WIDTH     (4),
    .TDEST_WIDTH   (4),
    .TUSER_WIDTH   (1),
    .MAX_PKT_LEN   (MAXLEN),
    .STALL_TIMEOUT (TIMEOUT),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .clear_errs (clear_errs),
    .tvalid     (tvalid),
    .tready     (tready),
    .tdata      (tdata),
    .tstrb      (tstrb),
    .tkeep      (tkeep),
    .tlast      (tlast),
    .tid        (tid),
    .tdest      (tdest),
    .tuser      (tuser),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .pkt_cnt    (pkt_cnt),
    .in_pkt     (in_pkt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CAP_W-1:0] cur_beat();
    return {tdata, tstrb, tkeep, tlast, tid, tdest, tuser};
  endfunction

  task automatic model_reset();
    m_hold = 0; m_cap = '0; m_run = 0; m_beats = 0; m_route = '0;
    m_pulse = '0; m_sticky = '0; m_err_cnt = 0; m_pkt_cnt = 0;
  endtask

  // Apply the protocol rules to the sample seen at this clock edge.
  task automatic model_step();
    logic [5:0] e;
    bit hs;
    bit stall;
    hs    = tvalid && tready;
    stall = tvalid && !tready;
    e     = '0;
    if (m_hold && tvalid && cur_beat() != m_cap) e[0] = 1'b1;
    if (m_hold && !tvalid) e[1] = 1'b1;
    if (tvalid && ((tstrb & ~tkeep) != '0)) e[2] = 1'b1;
    if (hs && m_beats > 0 && {tid, tdest} != m_route) e[3] = 1'b1;
    if (hs && (m_beats + 1) == MAXLEN + 1) e[4] = 1'b1;
    m_run = stall ? m_run + 1 : 0;
    if (stall && m_run == TIMEOUT) e[5] = 1'b1;
    if (stall && !m_hold) m_cap = cur_beat();
    m_hold = stall;
    if (hs) begin
      if (m_beats == 0) m_route = {tid, tdest};
      if (tlast) begin
        m_beats = 0;
        if (m_pkt_cnt < CMAX) m_pkt_cnt++;
      end else begin
        m_beats++;
      end
    end
    if (!enable) e = '0;
    m_pulse = e;
    if (clear_errs) begin
      m_sticky  = e;
      m_err_cnt = (e != '0) ? 1 : 0;
    end else begin
      m_sticky = m_sticky | e;
      if (e != '0 && m_err_cnt < CMAX) m_err_cnt++;
    end
  endtask

  // One clock: model consumes the sample, outputs compared just after the edge.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("err_pulse", 64'(err_pulse), 64'(m_pulse));
    check("err_sticky", 64'(err_sticky), 64'(m_sticky));
    check("err_cnt", 64'(err_cnt), 64'(m_err_cnt));
    check("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt_cnt));
    check("in_pkt", 64'(in_pkt), 64'(m_beats > 0));
  endtask

  task automatic drive(input bit v, input bit r, input logic [DW-1:0] d, input bit l);
    tvalid = v; tready = r; tdata = d; tlast = l; tstrb = '1; tkeep = '1;
  endtask

  task automatic clear_step();
    drive(0, 0, '0, 0);
    clear_errs = 1'b1;
    step();
    clear_errs = 1'b0;
  endtask

  initial begin
    int hits;
    int at;
    int p_ready;
    reset_n = 1'b0; enable = 1'b1; clear_errs = 1'b0;
    drive(0, 0, '0, 0);
    tid = '0; tdest = '0; tuser = '0;
    model_reset();
    #12;
    check("rst_pulse", 64'(err_pulse), 64'(0));
    check("rst_sticky", 64'(err_sticky), 64'(0));
    check("rst_err_cnt", 64'(err_cnt), 64'(0));
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
    check("rst_in_pkt", 64'(in_pkt), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Payload changes while stalled.
    drive(1, 0, 32'hA5, 0); step();
    drive(1, 0, 32'h5A, 0); step();
    check("stable_bit", 64'(err_pulse[0]), 64'(1));
    check("stable_cnt", 64'(err_cnt), 64'(1));
    drive(1, 0, 32'h5A, 0); step();
    drive(1, 1, 32'h5A, 1); step();
    drive(0, 0, '0, 0); step();

    // tvalid withdrawn before acceptance.
    clear_step();
    drive(1, 0, 32'h1, 0); step();
    drive(0, 0, '0, 0); step();
    check("drop_pulse", 64'(err_pulse), 64'(6'b000010));
    check("drop_sticky", 64'(err_sticky), 64'(6'b000010));
    step();

    // Six-beat packet against a four-beat limit.
    clear_step();
    hits = 0; at = 0;
    for (int b = 1; b <= 6; b++) begin
      drive(1, 1, 32'(b), b == 6);
      step();
      if (err_pulse[4]) begin hits++; at = b; end
    end
    check("too_long_hits", 64'(hits), 64'(1));
    check("too_long_beat", 64'(at), 64'(5));
    check("too_long_pkts", 64'(pkt_cnt), 64'(2));

    // Long stall, timeout flagged once.
    clear_step();
    hits = 0; at = 0;
    drive(1, 0, 32'h77, 0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (err_pulse[5]) begin hits++; at = i; end
    end
    check("stall_hits", 64'(hits), 64'(1));
    check("stall_cycle", 64'(at), 64'(8));
    check("stall_cnt", 64'(err_cnt), 64'(1));
    drive(1, 1, 32'h77, 1); step();
    drive(0, 0, '0, 0); step();

    // Routing change plus strobe outside keep on the same beat.
    clear_step();
    tid = 4'd3; drive(1, 1, 32'h1, 0); step();
    tid = 4'd5; drive(1, 1, 32'h2, 1); tstrb = 4'b1000; tkeep = 4'b0111; step();
    check("route_pulse", 64'(err_pulse), 64'(6'b001100));
    check("route_cnt", 64'(err_cnt), 64'(1));
    tid = '0; drive(0, 0, '0, 0); step();

    // Clear coinciding with a fresh error.
    clear_errs = 1'b1;
    drive(1, 1, 32'h3, 1); tstrb = 4'b1000; tkeep = 4'b0111; step();
    clear_errs = 1'b0;
    check("clr_new_sticky", 64'(err_sticky), 64'(6'b000100));
    check("clr_new_cnt", 64'(err_cnt), 64'(1));

    // Reporting disabled: errors suppressed, state keeps tracking.
    enable = 1'b0;
    drive(1, 0, 32'h9, 0); step();
    drive(0, 0, '0, 0); step();
    check("dis_pulse", 64'(err_pulse), 64'(0));
    check("dis_sticky", 64'(err_sticky), 64'(6'b000100));
    enable = 1'b1;

    // Reset in the middle of a packet discards its tracking.
    drive(1, 1, 32'h1, 0); step();
    drive(1, 1, 32'h2, 0); step();
    check("mid_in_pkt", 64'(in_pkt), 64'(1));
    drive(0, 0, '0, 0);
    #2 reset_n = 1'b0;
    #1;
    check("rst2_pkt_cnt", 64'(pkt_cnt), 64'(0));
    check("rst2_in_pkt", 64'(in_pkt), 64'(0));
    check("rst2_sticky", 64'(err_sticky), 64'(0));
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    tid = 4'd7;
    for (int b = 1; b <= 3; b++) begin
      drive(1, 1, 32'(b), b == 3);
      step();
    end
    drive(0, 0, '0, 0); step();
    check("post_rst_pkts", 64'(pkt_cnt), 64'(1));
    check("post_rst_in_pkt", 64'(in_pkt), 64'(0));
    check("post_rst_sticky", 64'(err_sticky), 64'(0));

    // Randomized traffic with varying backpressure.
    for (int ph = 0; ph < 3; ph++) begin
      p_ready = (ph == 0) ? 50 : (ph == 1) ? 90 : 10;
      for (int c = 0; c < 1000; c++) begin
        enable     = ($urandom % 16) != 0;
        clear_errs = ($urandom % 32) == 0;
        if (!(tvalid && !tready && ($urandom % 8) != 0)) begin
          tvalid = ($urandom % 4) != 0;
          tdata  = $urandom;
          tlast  = ($urandom % 4) == 0;
          tkeep  = (($urandom % 8) == 0) ? TBW'($urandom) : '1;
          tstrb  = (($urandom % 8) == 0) ? TBW'($urandom) : tkeep;
          tid    = (($urandom % 8) == 0) ? 4'($urandom) : 4'd1;
          tdest  = (($urandom % 8) == 0) ? 4'($urandom) : 4'd2;
          tuser  = 1'($urandom);
        end
        tready = $urandom_range(0, 99) < p_ready;
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
